count_display_driver: RTL and testbench
=======================================

// Module: count_display_driver
// PURPOSE
//   Downstream consumer of tt_um_multimode_counter's 8-bit count. Converts each offered
//   binary value to 3 BCD digits with a sequential double-dabble, then time-multiplexes the
//   digits onto one common 7-segment bus for the board display.
//   Lives in the same TinyTapeout design and drives uo_out / uio_out display pins.
// PARAMETERS
//   REFRESH_DIV    1024  clk cycles each digit is shown; legal 2..65535
//   BLANK_LEADING  1     1 = blank leading-zero hundreds/tens digits; 0 = always show all 3
// PORTS
//   clk          in   1  system clock; single clock domain
//   rst_n        in   1  asynchronous active-low reset
//   count_in     in   8  binary count from counter
//   count_valid  in   1  count_in is valid this cycle
//   ready        out  1  high = converter idle; value accepted on count_valid && ready
//   overrun      out  1  1-cycle pulse: count_valid seen while ready=0 (value dropped)
//   seg          out  7  segments {g,f,e,d,c,b,a}, active-high
//   digit_en     out  3  one-hot digit select, bit0 = ones, bit2 = hundreds, active-high
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, ready=1, overrun=0, BCD display regs=0,
//     prescaler=0, digit index=0, seg=7'h00, digit_en=3'b000.
//   Converter FSM: IDLE -> SHIFT -> LATCH -> IDLE.
//     IDLE : ready=1. On count_valid at edge N: load shift reg, bit counter=0, -> SHIFT.
//     SHIFT: per cycle: add 3 to every BCD nibble >=5, then shift left 1 bit; 8 cycles
//            (edges N+1..N+8); after the 8th shift -> LATCH.
//     LATCH: at edge N+9, copy {hund[1:0], tens[3:0], ones[3:0]} to display regs, -> IDLE.
//     Latency: accepted at edge N, display regs updated at edge N+9; ready high again after N+9.
//   count_valid while ready=0: value ignored, overrun=1 for exactly the next cycle. No queue.
//   count_valid held high continuously: a new sample is taken every 10 cycles; overrun pulses
//     on each cycle it is ignored.
//   Width: hundreds is 2 bits (max 2); 255 -> 2/5/5, 0 -> 0/0/0.
//   Refresh: prescaler counts 0..REFRESH_DIV-1 and wraps. On the wrap edge the digit index
//     advances 0->1->2->0, and seg/digit_en are registered from the display regs for the new
//     index. First non-zero digit_en appears at edge REFRESH_DIV after reset release (index 1).
//   Blanking (BLANK_LEADING=1): hundreds blanked if 0; tens blanked if hundreds=0 and tens=0;
//     ones never blanked. Blanked digit: digit_en still asserted, seg=7'h00.
//   Display regs change only in LATCH; a mid-refresh update takes effect on the next wrap.
//   Reset mid-conversion: partial result discarded, display regs return to 0.
// STRUCTURE
//   Shared include mmc_pkg.vh: FSM state localparams (IDLE/SHIFT/LATCH), 7-segment
//     glyph table for 0-9, SEG_BLANK, digit-index localparams.
//   One sub-module: bcd_dd8 (8-bit sequential double-dabble: start, data, busy, done, bcd[9:0]).
//   Top holds the handshake/overrun logic, display regs, prescaler, digit mux and blanking.
// TESTING (REFRESH_DIV=4 for benches)
//   Reset: rst_n low mid-run -> ready=1, seg=0, digit_en=0 immediately (async, no clk edge).
//   Offer 8'd123 one cycle -> ready low for 9 cycles; display regs 1/2/3 after edge N+9;
//     scan shows ones 7'h4F, tens 7'h5B, hundreds 7'h06.
//   Offer 8'd7 -> hundreds and tens blanked (seg=0 while their digit_en is active), ones
//     shows 7'h07; with BLANK_LEADING=0 they show 7'h3F.
//   Boundaries: 0 -> 0/0/0 with only ones lit (7'h3F); 255 -> 2/5/5; 100 -> 1/0/0
//     (inner tens zero not blanked).
//   Hold count_valid=1 with count_in incrementing -> samples every 10 cycles, overrun pulses
//     9 times per sample, no corrupted digits.
//   Refresh order: digit_en cycles 001->010->100->001, each held exactly REFRESH_DIV cycles.

Source files
------------

// File: rtl/count_display_driver_pkg.sv
// rtl/count_display_driver_pkg.sv - shared types, glyphs and digit indices for the count display driver
package count_display_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_HUND = 2'd2;

  // Segment order {g,f,e,d,c,b,a}, active-high
  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    case (d)
      4'd0:    seg_glyph = 7'h3F;
      4'd1:    seg_glyph = 7'h06;
      4'd2:    seg_glyph = 7'h5B;
      4'd3:    seg_glyph = 7'h4F;
      4'd4:    seg_glyph = 7'h66;
      4'd5:    seg_glyph = 7'h6D;
      4'd6:    seg_glyph = 7'h7D;
      4'd7:    seg_glyph = 7'h07;
      4'd8:    seg_glyph = 7'h7F;
      4'd9:    seg_glyph = 7'h6F;
      default: seg_glyph = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/count_display_driver_bcd_dd8.sv
// rtl/count_display_driver_bcd_dd8.sv - 8-bit sequential double-dabble, one shift per cycle
module bcd_dd8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic [9:0] bcd
);

  logic [7:0]  sh;
  logic [9:0]  acc;
  logic [2:0]  cnt;
  logic [3:0]  ones_adj;
  logic [3:0]  tens_adj;
  logic [17:0] shifted;

  // Hundreds never exceeds 2 for an 8-bit input, so it needs no correction
  always_comb begin
    ones_adj = (acc[3:0] >= 4'd5) ? acc[3:0] + 4'd3 : acc[3:0];
    tens_adj = (acc[7:4] >= 4'd5) ? acc[7:4] + 4'd3 : acc[7:4];
    shifted  = {acc[9:8], tens_adj, ones_adj, sh} << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start && !busy) begin
      sh   <= data;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc <= shifted[17:8];
      sh  <= shifted[7:0];
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7)
        busy <= 1'b0;
    end
  end

  // High during the cycle whose closing edge performs the final shift
  assign done = busy && (cnt == 3'd7);
  assign bcd  = acc;

endmodule

// File: rtl/count_display_driver.sv
// rtl/count_display_driver.sv - binary count to 3-digit multiplexed 7-segment display
module count_display_driver
  import count_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV   = 1024,
  parameter int BLANK_LEADING = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] count_in,
  input  logic       count_valid,
  output logic       ready,
  output logic       overrun,
  output logic [6:0] seg,
  output logic [2:0] digit_en
);

  conv_state_t state, state_nxt;
  logic        dd_start;
  logic        dd_busy;
  logic        dd_done;
  logic [9:0]  dd_bcd;

  logic [1:0]  disp_hund;
  logic [3:0]  disp_tens;
  logic [3:0]  disp_ones;

  logic [15:0] prescaler;
  logic        wrap;
  logic [1:0]  idx;
  logic [1:0]  idx_nxt;
  logic        hund_blank;
  logic        tens_blank;
  logic [6:0]  seg_nxt;
  logic [2:0]  en_nxt;

  assign ready    = (state == ST_IDLE);
  assign dd_start = ready && count_valid && !dd_busy;

  bcd_dd8 u_dd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (dd_start),
    .data  (count_in),
    .busy  (dd_busy),
    .done  (dd_done),
    .bcd   (dd_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (dd_start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (dd_done)  state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      disp_hund <= '0;
      disp_tens <= '0;
      disp_ones <= '0;
    end else begin
      overrun <= count_valid && !ready;
      if (state == ST_LATCH) begin
        disp_hund <= dd_bcd[9:8];
        disp_tens <= dd_bcd[7:4];
        disp_ones <= dd_bcd[3:0];
      end
    end
  end

  assign wrap    = (prescaler == 16'(REFRESH_DIV - 1));
  assign idx_nxt = (idx == DIG_HUND) ? DIG_ONES : idx + 2'd1;

  // Leading zeros are blanked but the digit stays enabled so the scan timing is uniform
  assign hund_blank = (BLANK_LEADING != 0) && (disp_hund == 2'd0);
  assign tens_blank = hund_blank && (disp_tens == 4'd0);

  always_comb begin
    seg_nxt = SEG_BLANK;
    en_nxt  = 3'b000;
    case (idx_nxt)
      DIG_ONES: begin
        en_nxt  = 3'b001;
        seg_nxt = seg_glyph(disp_ones);
      end
      DIG_TENS: begin
        en_nxt  = 3'b010;
        seg_nxt = tens_blank ? SEG_BLANK : seg_glyph(disp_tens);
      end
      default: begin
        en_nxt  = 3'b100;
        seg_nxt = hund_blank ? SEG_BLANK : seg_glyph({2'b00, disp_hund});
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      idx       <= DIG_ONES;
      seg       <= SEG_BLANK;
      digit_en  <= 3'b000;
    end else begin
      prescaler <= wrap ? 16'd0 : prescaler + 16'd1;
      if (wrap) begin
        idx      <= idx_nxt;
        seg      <= seg_nxt;
        digit_en <= en_nxt;
      end
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// tb/tb_count_display_driver.sv - directed table-driven bench for count_display_driver
module tb_count_display_driver;

  localparam int DIV = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] count_in;
  logic       count_valid;
  logic       ready_b, overrun_b, ready_n, overrun_n;
  logic [6:0] seg_b, seg_n;
  logic [2:0] den_b, den_n;

  int checks;
  int errors;
  logic [7:0] cap_b [3];
  logic [7:0] cap_n [3];

  typedef struct {
    logic [7:0] val;
    logic [6:0] h_b, t_b, o_b;
    logic [6:0] h_n, t_n, o_n;
  } vec_t;

  vec_t vecs [6];

  count_display_driver #(.REFRESH_DIV(DIV), .BLANK_LEADING(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .count_in(count_in), .count_valid(count_valid),
    .ready(ready_b), .overrun(overrun_b), .seg(seg_b), .digit_en(den_b)
  );

  count_display_driver #(.REFRESH_DIV(DIV), .BLANK_LEADING(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .count_in(count_in), .count_valid(count_valid),
    .ready(ready_n), .overrun(overrun_n), .seg(seg_n), .digit_en(den_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic scan();
    for (int d = 0; d < 3; d++) begin
      cap_b[d] = 8'hFF;
      cap_n[d] = 8'hFF;
    end
    repeat (4 * DIV) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (den_b[d]) cap_b[d] = {1'b0, seg_b};
        if (den_n[d]) cap_n[d] = {1'b0, seg_n};
      end
    end
  endtask

  task automatic check_scan(input vec_t v);
    scan();
    chk($sformatf("hund_blk(%0d)", v.val), cap_b[2], {1'b0, v.h_b});
    chk($sformatf("tens_blk(%0d)", v.val), cap_b[1], {1'b0, v.t_b});
    chk($sformatf("ones_blk(%0d)", v.val), cap_b[0], {1'b0, v.o_b});
    chk($sformatf("hund_all(%0d)", v.val), cap_n[2], {1'b0, v.h_n});
    chk($sformatf("tens_all(%0d)", v.val), cap_n[1], {1'b0, v.t_n});
    chk($sformatf("ones_all(%0d)", v.val), cap_n[0], {1'b0, v.o_n});
  endtask

  task automatic offer(input logic [7:0] v);
    @(negedge clk);
    count_in    = v;
    count_valid = 1'b1;
    @(negedge clk);
    count_valid = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [2:0] exp_en;
    int ovr_count;
    vec_t v50, v0;

    checks = 0;
    errors = 0;
    vecs[0] = '{8'd123, 7'h06, 7'h5B, 7'h4F, 7'h06, 7'h5B, 7'h4F};
    vecs[1] = '{8'd7,   7'h00, 7'h00, 7'h07, 7'h3F, 7'h3F, 7'h07};
    vecs[2] = '{8'd0,   7'h00, 7'h00, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    vecs[3] = '{8'd255, 7'h5B, 7'h6D, 7'h6D, 7'h5B, 7'h6D, 7'h6D};
    vecs[4] = '{8'd100, 7'h06, 7'h3F, 7'h3F, 7'h06, 7'h3F, 7'h3F};
    vecs[5] = '{8'd45,  7'h00, 7'h66, 7'h6D, 7'h3F, 7'h66, 7'h6D};
    v50     = '{8'd50,  7'h00, 7'h6D, 7'h3F, 7'h3F, 7'h6D, 7'h3F};
    v0      = '{8'd0,   7'h00, 7'h00, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    rst_n       = 1'b0;
    count_in    = 8'd0;
    count_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {7'd0, ready_b}, 8'd1);
    chk("rst_overrun", {7'd0, overrun_b}, 8'd0);
    chk("rst_seg", {1'b0, seg_b}, 8'h00);
    chk("rst_digit_en", {5'd0, den_b}, 8'h00);

    // Refresh order: first wrap at edge DIV selects tens, then hundreds, then ones
    rst_n = 1'b1;
    for (int k = 1; k <= 4 * DIV; k++) begin
      @(negedge clk);
      case (k / DIV)
        0:       exp_en = 3'b000;
        1:       exp_en = 3'b010;
        2:       exp_en = 3'b100;
        3:       exp_en = 3'b001;
        default: exp_en = 3'b010;
      endcase
      chk($sformatf("refresh_k%0d", k), {5'd0, den_b}, {5'd0, exp_en});
    end

    // Handshake latency: ready low for exactly 9 cycles after acceptance
    @(negedge clk);
    count_in    = vecs[0].val;
    count_valid = 1'b1;
    @(negedge clk);
    count_valid = 1'b0;
    chk("busy_c0", {7'd0, ready_b}, 8'd0);
    for (int i = 1; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("busy_c%0d", i), {7'd0, ready_b}, 8'd0);
    end
    @(negedge clk);
    chk("ready_after", {7'd0, ready_b}, 8'd1);
    check_scan(vecs[0]);

    for (int i = 1; i < 6; i++) begin
      offer(vecs[i].val);
      check_scan(vecs[i]);
    end

    // Continuous valid: accepts at j=0,10,20; the other cycles are dropped with overrun
    ovr_count = 0;
    for (int j = 0; j <= 20; j++) begin
      @(negedge clk);
      chk($sformatf("hold_ready_j%0d", j), {7'd0, ready_b}, {7'd0, (j % 10) == 0});
      chk($sformatf("hold_ovr_j%0d", j), {7'd0, overrun_b},
          {7'd0, (j > 0) && (((j - 1) % 10) != 0)});
      if (overrun_b) ovr_count++;
      count_in    = 8'(30 + j);
      count_valid = 1'b1;
    end
    @(negedge clk);
    chk("hold_ovr_end", {7'd0, overrun_b}, 8'd0);
    count_valid = 1'b0;
    chk("hold_ovr_total", 8'(ovr_count), 8'd18);
    repeat (10) @(negedge clk);
    check_scan(v50);

    // Asynchronous reset in the middle of a conversion
    @(negedge clk);
    count_in    = 8'd200;
    count_valid = 1'b1;
    @(negedge clk);
    count_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ready", {7'd0, ready_b}, 8'd1);
    chk("async_seg", {1'b0, seg_b}, 8'h00);
    chk("async_digit_en", {5'd0, den_b}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_scan(v0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
